fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
- Writer side of the FIR coefficient interface: takes a valid/ready coefficient stream from the control path (host/UART/register bridge) and drives fir_filter's filter_coefficients array.
- Double-buffered: words fill a shadow bank; the shadow bank becomes the active bank only on a sample strobe.
- The filter therefore never multiplies one sample against a half-updated coefficient set.

Parameters:
- FILTER_BITS, 12, coefficient width; must match fir_filter FILTER_BITS.
- FILTER_TAPS, 64, number of taps; must match fir_filter FILTER_TAPS; must be ≥2.
- COUNT_BITS, $clog2(FILTER_TAPS), width of the write index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- coeff_valid  in  1  stream word valid.
- coeff_data  in  FILTER_BITS  coefficient word. Word k drives filter_coefficients[k], in order 0..FILTER_TAPS-1.
- coeff_last  in  1  marks the final word of a set.
- coeff_ready  out  1  loader can accept a word.
- sample_strobe  in  1  same signal as fir_filter data_in_ready; sets the swap boundary.
- filter_coefficients  out  [FILTER_BITS] x FILTER_TAPS  active bank; connects to fir_filter.
- swap_done  out  1  one-cycle pulse when the active bank updates.
- load_error  out  1  one-cycle pulse on a malformed set.
- bank_id  out  1  toggles on every swap.
- busy  out  1  high whenever state ≠ LOAD or the write index ≠ 0.

Behaviour:
- Reset (rst=0, async):
  - Active and shadow banks = 0; write index = 0; state = LOAD.
  - coeff_ready=1, swap_done=0, load_error=0, bank_id=0, busy=0.
  - Deassertion takes effect on the next clk edge.
- Handshake: a word transfers on a clk edge with coeff_valid && coeff_ready. coeff_ready is a registered state decode and does not depend on coeff_valid.
- State LOAD (coeff_ready=1). On each transfer:
  - shadow[idx] <= coeff_data.
  - If idx == FILTER_TAPS-1 and coeff_last: go to PENDING; idx <= 0.
  - If idx < FILTER_TAPS-1 and coeff_last (short set): pulse load_error; idx <= 0; stay in LOAD. The shadow contents are don't-care; the active bank is untouched.
  - If idx == FILTER_TAPS-1 and !coeff_last (long set): pulse load_error; idx <= 0; go to DRAIN.
  - Otherwise: idx <= idx+1.
- State PENDING (coeff_ready=0). Waits for sample_strobe.
  - On the strobe edge: active <= shadow (all taps in the same edge); bank_id toggles; swap_done pulses next cycle; go to LOAD.
  - New coefficients are visible from the cycle after the strobe. fir_filter's multiply stage samples coefficients one cycle after its shift, so the sample accepted on that strobe is the first one filtered with the new set.
- State DRAIN (coeff_ready=1): accepts and discards words. A transfer with coeff_last returns to LOAD with idx=0. No further load_error pulses while draining.
- Simultaneous events:
  - Strobe in LOAD or DRAIN: ignored.
  - Strobe on the same edge that the last word completes in LOAD: no swap. The swap waits for the next strobe in PENDING.
- Active bank is only written by a swap. It holds its value through errors, drains and idle periods indefinitely.
- Reset mid-load or in PENDING: the pending set is lost and the active bank returns to 0. Downstream sees zero output until a full set is loaded and swapped.
- Width rules: coefficients are stored verbatim with no sign extension or scaling. idx wraps only through the explicit resets above and never via modulo overflow.

Decomposition:
- Shared package fir_pkg:
  - FILTER_BITS and FILTER_TAPS defaults.
  - typedef coeff_t = logic [FILTER_BITS-1:0].
  - loader state enum {LOAD, PENDING, DRAIN}.
- No sub-module. The bank register array and the FSM/counter stay in one module. fir_filter is instantiated next to it at the top level, not inside it.

Test Plan:
- Reset, no stimulus → all 64 filter_coefficients = 0, coeff_ready=1, busy=0, bank_id=0.
- Stream words k+1 (k=0..63) with last on word 63, no strobe → coeff_ready=0, active still 0. Then one strobe → next cycle active[k]=k+1, swap_done pulses once, bank_id=1.
- Load set A (all 0x100) and swap, then stream set B (all 0x7FF) while strobes toggle every 4 cycles → active stays 0x100 until B's last word. The first strobe after that changes it to 0x7FF; no intermediate mix is ever observed.
- Short set: last asserted on word 10 → load_error pulses once, active unchanged, next full 64-word set loads and swaps correctly.
- Long set: 70 words with last on word 70 → load_error pulses at word 64, words 65..70 are accepted and discarded, returns to LOAD, active unchanged.
- rst asserted asynchronously mid-PENDING (between clk edges) → outputs go to reset values immediately, no swap_done; load after deassertion works normally.
- Integration with fir_filter: swap in a single-tap impulse set (coeff[0]=1, rest 0) → data_out equals the slice of input × 1 after the filter latency. The sample on the swap strobe is the first affected.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default filter geometry, coefficient word type and
// the coefficient loader state encoding.
package fir_pkg;

  localparam int FILTER_BITS_DEF = 12;
  localparam int FILTER_TAPS_DEF = 64;

  typedef logic [FILTER_BITS_DEF-1:0] coeff_t;

  // LOAD    : filling the shadow bank
  // PENDING : full set captured, waiting for a sample strobe to swap
  // DRAIN   : overlong set, discarding words until coeff_last
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } ld_state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream (valid/ready) between the control path and the loader.
//   coeff_valid : word valid       (master -> slave)
//   coeff_data  : coefficient word (master -> slave)
//   coeff_last  : final word of set(master -> slave)
//   coeff_ready : slave can accept (slave -> master)
interface fir_coeff_loader_if #(
  parameter int FILTER_BITS = fir_pkg::FILTER_BITS_DEF
);
  logic                   coeff_valid;
  logic [FILTER_BITS-1:0] coeff_data;
  logic                   coeff_last;
  logic                   coeff_ready;

  modport master (
    output coeff_valid, coeff_data, coeff_last,
    input  coeff_ready
  );

  modport slave (
    input  coeff_valid, coeff_data, coeff_last,
    output coeff_ready
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient writer. Stream words fill a shadow bank;
// a complete set is copied into the active bank (filter_coefficients) only on
// a sample strobe, so the filter never sees a half-updated coefficient set.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   s_coeff             : coefficient stream (slave side)
//   sample_strobe       : fir_filter data_in_ready; swap boundary
//   filter_coefficients : active bank, tap k in [k]
//   swap_done           : one-cycle pulse after the active bank updates
//   load_error          : one-cycle pulse on a short or long set
//   bank_id             : toggles on every swap
//   busy                : state != LOAD or write index != 0
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int FILTER_BITS = FILTER_BITS_DEF,
  parameter int FILTER_TAPS = FILTER_TAPS_DEF,
  parameter int COUNT_BITS  = $clog2(FILTER_TAPS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  fir_coeff_loader_if.slave                       s_coeff,
  input  logic                                    sample_strobe,
  output logic [FILTER_TAPS-1:0][FILTER_BITS-1:0] filter_coefficients,
  output logic                                    swap_done,
  output logic                                    load_error,
  output logic                                    bank_id,
  output logic                                    busy
);

  localparam logic [COUNT_BITS-1:0] LAST_IDX = COUNT_BITS'(FILTER_TAPS - 1);

  ld_state_t                               r_state;
  logic [COUNT_BITS-1:0]                   r_idx;
  logic [FILTER_TAPS-1:0][FILTER_BITS-1:0] r_shadow;
  logic [FILTER_TAPS-1:0][FILTER_BITS-1:0] r_active;
  logic                                    r_ready;
  logic                                    r_swap_done;
  logic                                    r_load_error;
  logic                                    r_bank_id;

  logic w_xfer;
  logic w_at_last;

  assign w_xfer    = s_coeff.coeff_valid && r_ready;
  assign w_at_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= LOAD;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_ready      <= 1'b1;
      r_swap_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_bank_id    <= 1'b0;
    end else begin
      r_swap_done  <= 1'b0;
      r_load_error <= 1'b0;
      case (r_state)
        LOAD: begin
          // Strobes are ignored here, including one coinciding with the
          // final word: the swap waits for a strobe seen in PENDING.
          if (w_xfer) begin
            r_shadow[r_idx] <= s_coeff.coeff_data;
            if (w_at_last) begin
              r_idx <= '0;
              if (s_coeff.coeff_last) begin
                r_state <= PENDING;
                r_ready <= 1'b0;
              end else begin
                r_state      <= DRAIN;
                r_load_error <= 1'b1;
              end
            end else if (s_coeff.coeff_last) begin
              r_idx        <= '0;
              r_load_error <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        PENDING: begin
          if (sample_strobe) begin
            r_active    <= r_shadow;
            r_bank_id   <= ~r_bank_id;
            r_swap_done <= 1'b1;
            r_state     <= LOAD;
            r_ready     <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_xfer && s_coeff.coeff_last) begin
            r_state <= LOAD;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= LOAD;
          r_idx   <= '0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_coeff.coeff_ready = r_ready;
  assign filter_coefficients = r_active;
  assign swap_done           = r_swap_done;
  assign load_error          = r_load_error;
  assign bank_id             = r_bank_id;
  assign busy                = (r_state != LOAD) || (r_idx != '0);

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;
  localparam int FB = 12;
  localparam int FT = 64;
  typedef logic [FT-1:0][FB-1:0] bank_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  sample_strobe = 1'b0;
  bank_t fc;
  logic  swap_done, load_error, bank_id, busy;

  fir_coeff_loader_if #(.FILTER_BITS(FB)) ifc ();

  fir_coeff_loader #(.FILTER_BITS(FB), .FILTER_TAPS(FT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_coeff             (ifc),
    .sample_strobe       (sample_strobe),
    .filter_coefficients (fc),
    .swap_done           (swap_done),
    .load_error          (load_error),
    .bank_id             (bank_id),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  bank_t sb_q[$];
  bank_t exp_active = '0;
  logic  exp_bank = 1'b0;
  bit    b_done;

  function automatic int first_diff(input bank_t a, input bank_t b);
    for (int k = 0; k < FT; k++) if (a[k] !== b[k]) return k;
    return 0;
  endfunction

  task automatic send(input logic [FB-1:0] d, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    ifc.coeff_valid = 1'b1;
    ifc.coeff_data  = d;
    ifc.coeff_last  = l;
    while (!ifc.coeff_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.coeff_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: coeff_ready=%b after %0d cycles, required 1", ifc.coeff_ready, t);
    end
    @(posedge clk); #1;
    ifc.coeff_valid = 1'b0;
    ifc.coeff_last  = 1'b0;
  endtask

  task automatic strobe_once();
    @(negedge clk);
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
  endtask

  // Full 64-word set; the expected bank enters the scoreboard once the
  // final word has been accepted.
  task automatic send_full(input bank_t s);
    for (int k = 0; k < FT; k++) send(s[k], k == FT - 1);
    sb_q.push_back(s);
  endtask

  // Strobe in PENDING and compare the new active bank with the scoreboard.
  task automatic swap_and_check(input string nm);
    bank_t e;
    strobe_once();
    n_cmp++;
    if (swap_done !== 1'b1) begin
      n_bad++; $display("FAIL %s_swap_done: got %b, required 1", nm, swap_done);
    end
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL %s_scoreboard_empty: got 0 entries, required 1", nm);
    end else begin
      e = sb_q.pop_front();
      exp_active = e;
      exp_bank   = ~exp_bank;
      n_cmp++;
      if (fc !== e) begin
        n_bad++;
        $display("FAIL %s_active: tap %0d got %h, required %h", nm,
                 first_diff(fc, e), fc[first_diff(fc, e)], e[first_diff(fc, e)]);
      end
    end
    n_cmp++;
    if (bank_id !== exp_bank) begin
      n_bad++; $display("FAIL %s_bank_id: got %b, required %b", nm, bank_id, exp_bank);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (swap_done !== 1'b0) begin
      n_bad++; $display("FAIL %s_swap_pulse_width: got %b, required 0", nm, swap_done);
    end
  endtask

  task automatic test_reset();
    ifc.coeff_valid = 1'b0; ifc.coeff_data = '0; ifc.coeff_last = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (fc !== '0) begin n_bad++; $display("FAIL reset_active: nonzero tap %0d = %h, required 0", first_diff(fc, '0), fc[first_diff(fc, '0)]); end
    n_cmp++;
    if ({ifc.coeff_ready, busy, bank_id, swap_done, load_error} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_flags: ready/busy/bank/swap/err=%b, required 10000",
                        {ifc.coeff_ready, busy, bank_id, swap_done, load_error});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_swap();
    bank_t s;
    for (int k = 0; k < FT; k++) s[k] = FB'(k + 1);
    send_full(s);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ifc.coeff_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL pending_flags: ready=%b busy=%b, required ready=0 busy=1", ifc.coeff_ready, busy);
    end
    n_cmp++;
    if (fc !== exp_active) begin n_bad++; $display("FAIL pending_active_held: tap %0d got %h, required %h", first_diff(fc, exp_active), fc[first_diff(fc, exp_active)], exp_active[first_diff(fc, exp_active)]); end
    swap_and_check("ramp");
  endtask

  task automatic test_double_buffer();
    bank_t a, b;
    int    swaps;
    for (int k = 0; k < FT; k++) begin a[k] = 12'h100; b[k] = 12'h7FF; end
    send_full(a);
    swap_and_check("setA");
    b_done = 1'b0;
    swaps  = 0;
    fork
      begin
        for (int k = 0; k < FT; k++) send(b[k], k == FT - 1);
        sb_q.push_back(b);
        b_done = 1'b1;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          repeat (3) @(posedge clk);
          strobe_once();
        end
      end
      begin
        for (int c = 0; c < 110; c++) begin
          @(negedge clk);
          n_cmp++;
          if (fc !== a && fc !== b) begin
            n_bad++; $display("FAIL db_mixed_bank: tap0=%h tap63=%h, required all 100 or all 7ff", fc[0], fc[FT-1]);
          end else if (fc === b && !b_done) begin
            n_bad++; $display("FAIL db_early_swap: active=7ff before set B complete, required 100");
          end
          if (swap_done) swaps++;
        end
      end
    join
    n_cmp++;
    if (swaps != 1) begin n_bad++; $display("FAIL db_swap_count: got %0d, required 1", swaps); end
    if (sb_q.size() != 0) begin
      exp_active = sb_q.pop_front();
      exp_bank   = ~exp_bank;
    end
    n_cmp++;
    if (fc !== exp_active || bank_id !== exp_bank) begin
      n_bad++; $display("FAIL db_final: tap0=%h bank=%b, required %h bank=%b", fc[0], bank_id, exp_active[0], exp_bank);
    end
  endtask

  task automatic test_short();
    bank_t s;
    for (int k = 0; k < 10; k++) send(FB'(12'h0A0 + k), k == 9);
    n_cmp++;
    if (load_error !== 1'b1) begin n_bad++; $display("FAIL short_error: got %b, required 1", load_error); end
    strobe_once();  // strobe in LOAD is ignored
    n_cmp++;
    if (load_error !== 1'b0 || swap_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL short_after: err=%b swap=%b busy=%b, required 0 0 0", load_error, swap_done, busy);
    end
    n_cmp++;
    if (fc !== exp_active) begin n_bad++; $display("FAIL short_active_held: tap %0d got %h, required %h", first_diff(fc, exp_active), fc[first_diff(fc, exp_active)], exp_active[first_diff(fc, exp_active)]); end
    for (int k = 0; k < FT; k++) s[k] = FB'(12'hFFF - k * 3);
    send_full(s);
    swap_and_check("after_short");
  endtask

  task automatic test_long();
    int errs;
    for (int k = 0; k < FT; k++) send(FB'(12'h333), 1'b0);
    n_cmp++;
    if (load_error !== 1'b1 || busy !== 1'b1 || ifc.coeff_ready !== 1'b1) begin
      n_bad++; $display("FAIL long_error: err=%b busy=%b ready=%b, required 1 1 1", load_error, busy, ifc.coeff_ready);
    end
    errs = 0;
    for (int k = 65; k <= 70; k++) begin
      send(FB'(12'h555), k == 70);
      if (load_error) errs++;
    end
    n_cmp++;
    if (errs != 0) begin n_bad++; $display("FAIL long_drain_errors: got %0d, required 0", errs); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL long_return_load: busy=%b, required 0", busy); end
    strobe_once();
    n_cmp++;
    if (swap_done !== 1'b0 || fc !== exp_active || bank_id !== exp_bank) begin
      n_bad++; $display("FAIL long_active_held: swap=%b tap0=%h bank=%b, required 0 %h %b", swap_done, fc[0], bank_id, exp_active[0], exp_bank);
    end
  endtask

  task automatic test_async_reset();
    bank_t s;
    for (int k = 0; k < FT; k++) s[k] = FB'(k * 7);
    send_full(s);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (fc !== '0 || ifc.coeff_ready !== 1'b1 || busy !== 1'b0 || bank_id !== 1'b0 || swap_done !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: tap0=%h ready=%b busy=%b bank=%b swap=%b, required 0 1 0 0 0",
                        fc[0], ifc.coeff_ready, busy, bank_id, swap_done);
    end
    sb_q.delete();
    exp_active = '0;
    exp_bank   = 1'b0;
    strobe_once();
    n_cmp++;
    if (swap_done !== 1'b0 || fc !== '0) begin n_bad++; $display("FAIL reset_no_swap: swap=%b tap0=%h, required 0 0", swap_done, fc[0]); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < FT; k++) s[k] = FB'(12'h800 | k);
    send_full(s);
    swap_and_check("post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_swap();
    test_double_buffer();
    test_short();
    test_long();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
